// File: rtl/hash_axi_pkg.sv
// Shared constants, FSM encoding and the burst legality rule for the hash IP AXI4 slave.
`timescale 1ns/1ps
package hash_axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam int         REG_DEPTH   = 16;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_ACK,
    ST_AR_ACK,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } state_e;

  // A burst that fails this test is still consumed beat by beat, but never touches the register file.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != SIZE_4B) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Word-index and beat counter for one AXI4 burst; shared by the read and write paths.
`timescale 1ns/1ps
module axi4_burst_addr_gen
  import hash_axi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] start_idx_i,
  input  logic [7:0] len_i,
  input  logic [1:0] burst_i,
  input  logic       adv_i,
  output logic [3:0] idx_o,
  output logic [3:0] next_idx_o,
  output logic       last_o
);
  logic [3:0] idx_q, idx_d;
  logic [7:0] beat_q, beat_d;
  logic [3:0] idx_inc;
  logic [3:0] wrap_mask;

  always_comb begin
    idx_inc   = idx_q + 4'd1;
    wrap_mask = len_i[3:0];
    case (burst_i)
      BURST_INCR: next_idx_o = idx_inc;
      BURST_WRAP: next_idx_o = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
      default:    next_idx_o = idx_q;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    beat_d = beat_q;
    if (load_i) begin
      idx_d  = start_idx_i;
      beat_d = 8'd0;
    end else if (adv_i) begin
      idx_d  = next_idx_o;
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= 4'd0;
      beat_q <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      beat_q <= beat_d;
    end
  end

  assign idx_o  = idx_q;
  // len_i is the latched burst length, valid from the first data beat onward.
  assign last_o = (beat_q == len_i);
endmodule

// File: rtl/hash_axi4_burst_slave.sv
// AXI4 burst slave for the hash IP: one transaction at a time over a 16 x 32-bit register file.
`timescale 1ns/1ps
module hash_axi4_burst_slave
  import hash_axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                        AWLEN,
  input  logic [2:0]                        AWSIZE,
  input  logic [1:0]                        AWBURST,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                              WLAST,
  input  logic                              WVALID,
  output logic                              WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       BID,
  output logic [1:0]                        BRESP,
  output logic                              BVALID,
  input  logic                              BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                        ARLEN,
  input  logic [2:0]                        ARSIZE,
  input  logic [1:0]                        ARBURST,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RLAST,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [REG_DEPTH*C_S_AXI_DATA_WIDTH-1:0] regfile_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  state_e                      state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [7:0]                  len_q;
  logic [1:0]                  burst_q;
  logic                        err_q;
  logic                        wlast_err_q;
  logic [1:0]                  bresp_q;
  logic [DW-1:0]               rdata_q;
  logic [DW-1:0]               mem_q [REG_DEPTH];

  logic       aw_hs, ar_hs, w_beat, r_beat;
  logic       ag_load, ag_adv, ag_last;
  logic [3:0] ag_start, ag_idx, ag_next_idx;
  logic       wlast_bad;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  assign aw_hs     = (state_q == ST_AW_ACK) && AWVALID;
  assign ar_hs     = (state_q == ST_AR_ACK) && ARVALID;
  assign w_beat    = (state_q == ST_WDATA) && WVALID;
  assign r_beat    = (state_q == ST_RDATA) && RREADY;
  assign ag_load   = aw_hs || ar_hs;
  assign ag_start  = aw_hs ? AWADDR[5:2] : ARADDR[5:2];
  assign ag_adv    = (w_beat || r_beat) && !ag_last;
  assign wlast_bad = (WLAST != ag_last);

  axi4_burst_addr_gen u_addr_gen (
    .clk_i       (ACLK),
    .rst_ni      (ARESETN),
    .load_i      (ag_load),
    .start_idx_i (ag_start),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .adv_i       (ag_adv),
    .idx_o       (ag_idx),
    .next_idx_o  (ag_next_idx),
    .last_o      (ag_last)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    AWREADY      = 1'b0;
    ARREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    RVALID       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Simultaneous requests alternate so neither channel can starve the other.
        if (AWVALID && ARVALID) begin
          if (last_grant_q == GRANT_READ) begin
            state_d      = ST_AW_ACK;
            last_grant_d = GRANT_WRITE;
          end else begin
            state_d      = ST_AR_ACK;
            last_grant_d = GRANT_READ;
          end
        end else if (AWVALID) begin
          state_d      = ST_AW_ACK;
          last_grant_d = GRANT_WRITE;
        end else if (ARVALID) begin
          state_d      = ST_AR_ACK;
          last_grant_d = GRANT_READ;
        end
      end
      ST_AW_ACK: begin
        AWREADY = 1'b1;
        if (AWVALID) state_d = ST_WDATA;
      end
      ST_AR_ACK: begin
        ARREADY = 1'b1;
        if (ARVALID) state_d = ST_RDATA;
      end
      ST_WDATA: begin
        WREADY = 1'b1;
        if (WVALID && ag_last) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        RVALID = 1'b1;
        if (RREADY && ag_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      id_q        <= '0;
      len_q       <= 8'd0;
      burst_q     <= BURST_FIXED;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      for (int k = 0; k < REG_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      if (aw_hs) begin
        id_q        <= AWID;
        len_q       <= AWLEN;
        burst_q     <= AWBURST;
        err_q       <= burst_err(AWSIZE, AWBURST, AWLEN);
        wlast_err_q <= 1'b0;
      end
      if (ar_hs) begin
        id_q    <= ARID;
        len_q   <= ARLEN;
        burst_q <= ARBURST;
        err_q   <= burst_err(ARSIZE, ARBURST, ARLEN);
        rdata_q <= burst_err(ARSIZE, ARBURST, ARLEN) ? '0 : mem_q[ARADDR[5:2]];
      end
      if (w_beat) begin
        if (!err_q) begin
          for (int b = 0; b < DW/8; b++) begin
            if (WSTRB[b]) mem_q[ag_idx][8*b +: 8] <= WDATA[8*b +: 8];
          end
        end
        if (wlast_bad) wlast_err_q <= 1'b1;
        if (ag_last) bresp_q <= (err_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
      // Prefetch the next beat so RDATA stays a register output and holds during stalls.
      if (r_beat && !ag_last) begin
        rdata_q <= err_q ? '0 : mem_q[ag_next_idx];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < REG_DEPTH; k++) regfile_o[DW*k +: DW] = mem_q[k];
  end

  assign BID   = id_q;
  assign BRESP = bresp_q;
  assign RID   = id_q;
  assign RDATA = rdata_q;
  assign RRESP = ((state_q == ST_RDATA) && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST = (state_q == ST_RDATA) && ag_last;
endmodule

// File: tb/tb_hash_axi4_burst_slave.sv
// Scoreboard bench: tasks push expected B/R responses from a word-array model; a monitor pops and compares.
`timescale 1ns/1ps
module tb_hash_axi4_burst_slave;
  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [0:0]   AWID = '0;
  logic [5:0]   AWADDR = '0;
  logic [7:0]   AWLEN = '0;
  logic [2:0]   AWSIZE = '0;
  logic [1:0]   AWBURST = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WLAST = 1'b0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [0:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [0:0]   ARID = '0;
  logic [5:0]   ARADDR = '0;
  logic [7:0]   ARLEN = '0;
  logic [2:0]   ARSIZE = '0;
  logic [1:0]   ARBURST = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [0:0]   RID;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [511:0] regfile_o;

  hash_axi4_burst_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .regfile_o(regfile_o)
  );

  initial forever #5 ACLK = ~ACLK;

  typedef struct { logic [0:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [0:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_pops = 0;
  bit          rr_auto = 1'b1;
  logic [31:0] mdl_mem [16];
  bit          mdl_lg = 1'b0;
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Reference model: word index of beat k from the AXI address rules.
  function automatic int exp_idx(input int start, input int len, input logic [1:0] burst, input int k);
    int sz, base;
    case (burst)
      2'b01:   return (start + k) % 16;
      2'b10: begin
        sz   = len + 1;
        base = (start / sz) * sz;
        return base + ((start % sz) + k) % sz;
      end
      default: return start;
    endcase
  endfunction

  function automatic bit exp_err(input logic [2:0] size, input logic [1:0] burst, input int len);
    if (size != 3'b010) return 1'b1;
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [511:0] mdl_flat();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = mdl_mem[k];
    return r;
  endfunction

  task automatic model_write(input logic [0:0] id, input logic [5:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad);
    bit e;
    int idx;
    b_exp_t x;
    e = exp_err(size, burst, len);
    if (!e) begin
      for (int k = 0; k <= len; k++) begin
        idx = exp_idx(int'(addr[5:2]), len, burst, k);
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) mdl_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
      end
    end
    x.id   = id;
    x.resp = (e || (bad >= 0 && bad <= len)) ? 2'b10 : 2'b00;
    bq.push_back(x);
  endtask

  task automatic model_read(input logic [0:0] id, input logic [5:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    bit e;
    r_exp_t x;
    e = exp_err(size, burst, len);
    for (int k = 0; k <= len; k++) begin
      x.id   = id;
      x.data = e ? 32'h0 : mdl_mem[exp_idx(int'(addr[5:2]), len, burst, k)];
      x.resp = e ? 2'b10 : 2'b00;
      x.last = (k == len);
      rq.push_back(x);
    end
  endtask

  task automatic bus_aw(input logic [0:0] id, input logic [5:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(posedge ACLK); #1;
    AWID = id; AWADDR = addr; AWLEN = len[7:0]; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 1000) begin @(negedge ACLK); n++; end
    if (!AWREADY) timeout_fail("aw_handshake");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic bus_ar(input logic [0:0] id, input logic [5:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(posedge ACLK); #1;
    ARID = id; ARADDR = addr; ARLEN = len[7:0]; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 1000) begin @(negedge ACLK); n++; end
    if (!ARREADY) timeout_fail("ar_handshake");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic bus_w(input int len, input int bad);
    int n;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        WVALID = 1'b0;
        @(posedge ACLK); #1;
      end
      WDATA = wd[k]; WSTRB = ws[k]; WLAST = (k == len) ^ (k == bad); WVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!WREADY && n < 1000) begin @(negedge ACLK); n++; end
      if (!WREADY) begin
        timeout_fail("w_beat");
        break;
      end
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (bq.size() != 0 && n < 2000) begin @(negedge ACLK); n++; end
    if (bq.size() != 0) timeout_fail("b_response");
  endtask

  task automatic wait_r();
    int n = 0;
    while (rq.size() != 0 && n < 2000) begin @(negedge ACLK); n++; end
    if (rq.size() != 0) timeout_fail("r_beats");
  endtask

  task automatic do_write(input logic [0:0] id, input logic [5:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad);
    model_write(id, addr, len, size, burst, bad);
    mdl_lg = 1'b1;
    bus_aw(id, addr, len, size, burst);
    bus_w(len, bad);
    wait_b();
  endtask

  task automatic do_read(input logic [0:0] id, input logic [5:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    model_read(id, addr, len, size, burst);
    mdl_lg = 1'b0;
    bus_ar(id, addr, len, size, burst);
    wait_r();
  endtask

  task automatic do_dual(input logic [5:0] waddr, input int wlen, input logic [1:0] wburst,
                         input logic [5:0] raddr, input int rlen, input logic [1:0] rburst);
    bit wfirst;
    wfirst = (mdl_lg == 1'b0);
    if (wfirst) begin
      model_write(1'b1, waddr, wlen, 3'b010, wburst, -1);
      model_read(1'b0, raddr, rlen, 3'b010, rburst);
      mdl_lg = 1'b0;
    end else begin
      model_read(1'b0, raddr, rlen, 3'b010, rburst);
      model_write(1'b1, waddr, wlen, 3'b010, wburst, -1);
      mdl_lg = 1'b1;
    end
    fork
      begin bus_aw(1'b1, waddr, wlen, 3'b010, wburst); bus_w(wlen, -1); wait_b(); end
      begin bus_ar(1'b0, raddr, rlen, 3'b010, rburst); wait_r(); end
      begin
        int n = 0;
        @(negedge ACLK);
        while (!AWREADY && !ARREADY && n < 200) begin @(negedge ACLK); n++; end
        if (!AWREADY && !ARREADY) timeout_fail("grant");
        else chk("grant_is_write", 512'(AWREADY), 512'(wfirst));
      end
    join
  endtask

  initial begin
    forever begin
      @(posedge ACLK); #1;
      if (rr_auto) RREADY = ($urandom_range(0, 3) != 0);
      BREADY = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compares every B/R handshake against the head of its queue and checks stall stability.
  initial begin
    bit          r_stall = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;
    b_exp_t      be;
    r_exp_t      re;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        r_stall = 1'b0;
      end else begin
        if (r_stall && RVALID) chk("rdata_hold", 512'({RLAST, RDATA}), 512'({p_last, p_data}));
        r_stall = RVALID && !RREADY;
        p_data  = RDATA;
        p_last  = RLAST;
        if (BVALID && BREADY) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got BRESP=%0h expected no response", BRESP);
          end else begin
            be = bq.pop_front();
            chk("bresp_bid", 512'({BID, BRESP}), 512'({be.id, be.resp}));
          end
        end
        if (RVALID && RREADY) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got RDATA=%0h expected no beat", RDATA);
          end else begin
            re = rq.pop_front();
            rd_pops++;
            chk("rdata", 512'(RDATA), 512'(re.data));
            chk("rid_rresp_rlast", 512'({RID, RRESP, RLAST}), 512'({re.id, re.resp, re.last}));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] addr;
    logic [1:0] bu;
    logic [2:0] sz;
    logic [0:0] id;
    int         len, sel, n;

    for (int k = 0; k < 16; k++) mdl_mem[k] = 32'h0;
    for (int k = 0; k < 256; k++) begin wd[k] = 32'h0; ws[k] = 4'hF; end

    // Reset state
    #12;
    chk("reset_ctrl", 512'({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST}), 512'(0));
    chk("reset_data", 512'({RDATA, BRESP, RRESP, BID, RID}), 512'(0));
    chk("reset_regfile", regfile_o, 512'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);

    // 1: INCR fill of all 16 words, WRAP read-back of the full block
    for (int k = 0; k < 16; k++) begin
      wd[k] = (k == 0) ? 32'hFFFF_FFFF : (k == 15) ? 32'h00ab_cdef : 32'h1111_1111 * k;
      ws[k] = 4'hF;
    end
    do_write(1'b0, 6'h00, 15, 3'b010, 2'b01, -1);
    chk("t1_regfile", regfile_o, mdl_flat());
    do_read(1'b1, 6'h00, 15, 3'b010, 2'b10);

    // 2: WRAP LEN=3 starting at word 14
    do_read(1'b0, 6'h38, 3, 3'b010, 2'b10);

    // 3: byte strobes over a cleared word, then FIXED read of it three times
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(1'b1, 6'h04, 0, 3'b010, 2'b01, -1);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
    do_write(1'b0, 6'h04, 0, 3'b010, 2'b01, -1);
    chk("t3_word1", 512'(regfile_o[63:32]), 512'(32'h00FF_00FF));
    do_read(1'b1, 6'h04, 2, 3'b010, 2'b00);

    // 4: simultaneous AW/AR, twice
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_dual(6'h10, 3, 2'b01, 6'h10, 3, 2'b01);
    for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_dual(6'h20, 1, 2'b10, 6'h20, 1, 2'b10);
    chk("t4_regfile", regfile_o, mdl_flat());

    // 5: error bursts
    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(1'b1, 6'h08, 1, 3'b001, 2'b01, -1);
    chk("t5_unchanged", regfile_o, mdl_flat());
    do_read(1'b0, 6'h00, 2, 3'b010, 2'b10);
    do_write(1'b0, 6'h0C, 2, 3'b010, 2'b11, -1);
    do_read(1'b1, 6'h0C, 2, 3'b010, 2'b11);
    do_write(1'b1, 6'h30, 3, 3'b010, 2'b01, 1);
    do_write(1'b0, 6'h30, 3, 3'b010, 2'b01, 3);
    chk("t5_regfile", regfile_o, mdl_flat());

    // Randomized mix, including LEN > 15 and occasional illegal fields
    for (int t = 0; t < 40; t++) begin
      bu   = 2'($urandom_range(0, 3));
      if (bu == 2'b10 && $urandom_range(0, 4) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 20);
      sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      addr = 6'($urandom);
      id   = 1'($urandom);
      for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      sel = $urandom_range(0, 4);
      if (sel <= 1)      do_write(id, addr, len, sz, bu, -1);
      else if (sel <= 3) do_read(id, addr, len, sz, bu);
      else               do_dual(addr, len, bu, 6'($urandom), $urandom_range(0, 7), 2'b01);
    end
    chk("rand_regfile", regfile_o, mdl_flat());

    // 6: reset in the middle of a stalled 16-beat read
    model_read(1'b0, 6'h00, 15, 3'b010, 2'b01);
    mdl_lg  = 1'b0;
    rr_auto = 1'b0;
    RREADY  = 1'b1;
    rd_pops = 0;
    bus_ar(1'b0, 6'h00, 15, 3'b010, 2'b01);
    n = 0;
    while (rd_pops < 5 && n < 200) begin @(negedge ACLK); n++; end
    if (rd_pops < 5) timeout_fail("t6_beats");
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    chk("t6_rvalid", 512'({RVALID, RLAST}), 512'(0));
    chk("t6_ready_valid", 512'({AWREADY, ARREADY, WREADY, BVALID}), 512'(0));
    chk("t6_regfile", regfile_o, 512'(0));
    rq.delete();
    for (int k = 0; k < 16; k++) mdl_mem[k] = 32'h0;
    mdl_lg = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    rr_auto = 1'b1;
    for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(1'b1, 6'h14, 1, 3'b010, 2'b01, -1);
    do_read(1'b0, 6'h10, 3, 3'b010, 2'b01);
    chk("t6_regfile_after", regfile_o, mdl_flat());

    repeat (4) @(posedge ACLK);
    chk("bq_empty", 512'(bq.size()), 512'(0));
    chk("rq_empty", 512'(rq.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
